// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: opcodes, branch funct3 codes, the canonical NOP
// and the immediate-format classification used by imm_gen.
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    fmt = IMM_NONE;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: fmt = IMM_I;
      OP_STORE:                 fmt = IMM_S;
      OP_BRANCH:                fmt = IMM_B;
      OP_LUI, OP_AUIPC:         fmt = IMM_U;
      OP_JAL:                   fmt = IMM_J;
      default:                  fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/id_branch_stage_if.sv
// Fetch <-> decode redirect bus: fetch presents pc/instr, decode answers with PCSrc/imm_ext.
interface id_branch_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            pc_src;
  logic [XLEN-1:0] imm_ext;

  modport master (
    output if_pc,
    output if_instr,
    input  pc_src,
    input  imm_ext
  );

  modport slave (
    input  if_pc,
    input  if_instr,
    output pc_src,
    output imm_ext
  );
endinterface

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extractor; opcodes without an immediate yield zero.
module imm_gen
  import rv_pkg::*;
(
  input  logic        [31:0] instr,
  output logic signed [31:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_fmt(instr[6:0]))
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_branch_stage.sv
// IF/ID slot with decode-stage branch/JAL/JALR resolution; a taken redirect squashes
// the single PC+4 instruction fetched behind it and bumps the redirect counter.
module id_branch_stage
  import rv_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  id_branch_stage_if.slave fetch,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  id_instr,
  output logic [XLEN-1:0]  id_imm,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  output logic [4:0]       rd_addr,
  output logic [XLEN-1:0]  id_link,
  output logic [CNT_W-1:0] redirect_cnt
);

  function automatic logic branch_cond(input logic [2:0] f3,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic                   cond;
    sa   = a;
    sb   = b;
    cond = 1'b0;
    case (f3)
      F3_BEQ:  cond = (a == b);
      F3_BNE:  cond = (a != b);
      F3_BLT:  cond = (sa < sb);
      F3_BGE:  cond = (sa >= sb);
      F3_BLTU: cond = (a < b);
      F3_BGEU: cond = (a >= b);
      default: cond = 1'b0;
    endcase
    return cond;
  endfunction

  logic                   vld_p0;
  logic        [XLEN-1:0] pc_p0;
  logic        [XLEN-1:0] instr_p0;
  logic        [CNT_W-1:0] cnt_q;
  logic signed [XLEN-1:0] imm_p0;
  logic        [6:0]      opcode_p0;
  logic        [2:0]      funct3_p0;
  logic                   taken_p0;
  logic        [XLEN-1:0] link_p0;
  logic        [XLEN-1:0] target_p0;

  // Stage p0: IF/ID register. A redirect at this edge writes the wrong-path fetch as a NOP bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0   <= 1'b0;
      pc_p0    <= RESET_PC;
      instr_p0 <= NOP;
      cnt_q    <= '0;
    end else begin
      vld_p0   <= !taken_p0;
      pc_p0    <= fetch.if_pc;
      instr_p0 <= taken_p0 ? NOP : fetch.if_instr;
      if (taken_p0) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  imm_gen u_imm_gen (
    .instr (instr_p0),
    .imm   (imm_p0)
  );

  assign opcode_p0 = instr_p0[6:0];
  assign funct3_p0 = instr_p0[14:12];
  assign link_p0   = pc_p0 + 32'd4;

  // Stage p0 decode: fetch already sits at id_pc+4, so the offset is taken relative to the link value.
  always_comb begin
    taken_p0  = 1'b0;
    target_p0 = pc_p0 + $unsigned(imm_p0);
    case (opcode_p0)
      OP_JAL:    taken_p0 = vld_p0;
      OP_JALR: begin
        taken_p0  = vld_p0;
        target_p0 = (rs1_data + $unsigned(imm_p0)) & ~32'd1;
      end
      OP_BRANCH: taken_p0 = vld_p0 && branch_cond(funct3_p0, rs1_data, rs2_data);
      default:   taken_p0 = 1'b0;
    endcase
  end

  assign fetch.pc_src  = taken_p0;
  assign fetch.imm_ext = taken_p0 ? (target_p0 - link_p0) : '0;

  assign id_valid     = vld_p0;
  assign id_pc        = pc_p0;
  assign id_instr     = instr_p0;
  assign id_imm       = imm_p0;
  assign rs1_addr     = instr_p0[19:15];
  assign rs2_addr     = instr_p0[24:20];
  assign rd_addr      = instr_p0[11:7];
  assign id_link      = link_p0;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_id_branch_stage.sv
// Bench for id_branch_stage: directed test-plan scenarios plus random instruction
// streams checked against a cycle-level behavioural model of the decode slot.
module tb_id_branch_stage;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        id_valid;
  logic [31:0] id_pc, id_instr, id_imm, id_link, redirect_cnt;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;

  id_branch_stage_if #(.XLEN(32)) fbus ();

  id_branch_stage #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch        (fbus),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_instr     (id_instr),
    .id_imm       (id_imm),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rd_addr      (rd_addr),
    .id_link      (id_link),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model state: what fetch handed over at the last edge, and whether that slot is live.
  bit          m_valid;
  logic [31:0] m_pc, m_instr, m_cnt;

  task automatic model_reset();
    m_valid = 0;
    m_pc    = 32'h0;
    m_instr = NOP_W;
    m_cnt   = 32'h0;
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int v;
    v = 0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67: v = (w[31] ? -2048 : 0) + int'(w[30:20]);
      7'h23: v = (w[31] ? -2048 : 0) + 32 * int'(w[30:25]) + int'(w[11:7]);
      7'h63: v = (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0) + 32 * int'(w[30:25]) + 2 * int'(w[11:8]);
      7'h6f: v = (w[31] ? -1048576 : 0) + 4096 * int'(w[19:12]) + (w[20] ? 2048 : 0) + 2 * int'(w[30:21]);
      7'h37, 7'h17: v = int'(w & 32'hFFFF_F000);
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic model_eval(output bit tk, output logic [31:0] ext);
    logic [31:0] imm, tgt, r1, r2;
    logic [2:0]  f3;
    imm = ref_imm(m_instr);
    r1  = rs1_data;
    r2  = rs2_data;
    f3  = m_instr[14:12];
    tk  = 0;
    tgt = m_pc + imm;
    if (m_valid) begin
      case (m_instr[6:0])
        7'h6f: tk = 1;
        7'h67: begin
          tk  = 1;
          tgt = ((r1 + imm) >> 1) << 1;
        end
        7'h63: begin
          case (f3)
            3'd0: tk = (r1 == r2);
            3'd1: tk = (r1 != r2);
            3'd4: tk = (int'(r1) < int'(r2));
            3'd5: tk = !(int'(r1) < int'(r2));
            3'd6: tk = (r1 < r2);
            3'd7: tk = !(r1 < r2);
            default: tk = 0;
          endcase
        end
        default: tk = 0;
      endcase
    end
    ext = tk ? (tgt - (m_pc + 32'd4)) : 32'h0;
  endtask

  // Present fetch/regfile inputs, compare all slot outputs to the model, then take one edge.
  task automatic step(input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] r1, input logic [31:0] r2);
    bit          tk;
    logic [31:0] ext, shown;
    fbus.if_pc    = pc;
    fbus.if_instr = instr;
    rs1_data      = r1;
    rs2_data      = r2;
    #1;
    model_eval(tk, ext);
    shown = m_valid ? m_instr : NOP_W;
    chk("id_valid", 32'(id_valid), 32'(m_valid));
    chk("id_pc", id_pc, m_pc);
    chk("id_instr", id_instr, shown);
    chk("id_imm", id_imm, ref_imm(shown));
    chk("reg_fields", {17'b0, rs1_addr, rs2_addr, rd_addr},
        {17'b0, shown[19:15], shown[24:20], shown[11:7]});
    chk("id_link", id_link, m_pc + 32'd4);
    chk("pc_src", 32'(fbus.pc_src), 32'(tk));
    chk("imm_ext", fbus.imm_ext, ext);
    chk("redirect_cnt", redirect_cnt, m_cnt);
    @(posedge clk);
    if (tk) m_cnt = m_cnt + 32'd1;
    m_valid = !tk;
    m_pc    = pc;
    m_instr = instr;
    #1;
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] a,
                                        input logic [4:0] b, input logic [12:0] off);
    return {off[12], off[10:5], b, a, f3, off[4:1], off[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [1:0] sel;
    sel = 2'($urandom_range(0, 3));
    case (sel)
      2'd0:    return 32'hFFFF_FFFF;
      2'd1:    return 32'h8000_0000;
      2'd2:    return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] addi, beq, blt, bltu, jal, jalr, cnt_before, w, r1, r2, pc;
    logic [6:0]  opcs [9];
    opcs = '{7'h63, 7'h63, 7'h6f, 7'h67, 7'h03, 7'h23, 7'h13, 7'h37, 7'h17};

    addi = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5);
    beq  = enc_b(3'd0, 5'd1, 5'd2, 13'd16);
    blt  = enc_b(3'd4, 5'd1, 5'd2, 13'd16);
    bltu = enc_b(3'd6, 5'd1, 5'd2, 13'd16);
    jal  = enc_j(5'd1, 21'h1F_FFF8);
    jalr = enc_i(7'h67, 3'd0, 5'd0, 5'd5, 12'd4);

    fbus.if_pc    = 32'h0;
    fbus.if_instr = addi;
    model_reset();
    #12;
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", id_instr, NOP_W);
    chk("rst_pc_src", 32'(fbus.pc_src), 32'd0);
    chk("rst_imm_ext", fbus.imm_ext, 32'd0);
    chk("rst_cnt", redirect_cnt, 32'd0);
    step(32'h0, addi, 32'h0, 32'h0);
    chk("addi_valid", 32'(id_valid), 32'd1);
    chk("addi_imm", id_imm, 32'd5);
    chk("addi_rd", 32'(rd_addr), 32'd1);
    chk("addi_pc_src", 32'(fbus.pc_src), 32'd0);

    // BEQ taken at 0x8
    step(32'h8, beq, 32'h0, 32'h0);
    rs1_data = 32'd7; rs2_data = 32'd7; #1;
    chk("beq_taken", 32'(fbus.pc_src), 32'd1);
    chk("beq_imm_ext", fbus.imm_ext, 32'h0000_000C);
    step(32'hC, addi, 32'd7, 32'd7);
    chk("beq_squash", 32'(id_valid), 32'd0);
    chk("beq_cnt", redirect_cnt, 32'd1);
    step(32'h18, addi, 32'd0, 32'd0);

    // BEQ not taken
    step(32'h8, beq, 32'd0, 32'd1);
    rs1_data = 32'd7; rs2_data = 32'd8; #1;
    chk("beq_nt", 32'(fbus.pc_src), 32'd0);
    chk("beq_nt_ext", fbus.imm_ext, 32'd0);
    step(32'hC, addi, 32'd7, 32'd8);
    chk("beq_nt_valid", 32'(id_valid), 32'd1);

    // Signed vs unsigned compare
    step(32'h40, blt, 32'd0, 32'd0);
    rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1; #1;
    chk("blt_taken", 32'(fbus.pc_src), 32'd1);
    step(32'h44, addi, 32'hFFFF_FFFF, 32'd1);
    step(32'h40, bltu, 32'd0, 32'd0);
    rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1; #1;
    chk("bltu_nt", 32'(fbus.pc_src), 32'd0);
    step(32'h44, addi, 32'hFFFF_FFFF, 32'd1);

    // JAL followed by a matching BEQ on the wrong path
    step(32'h10, jal, 32'd0, 32'd0);
    cnt_before = redirect_cnt;
    chk("jal_ext", fbus.imm_ext, 32'hFFFF_FFF4);
    chk("jal_link", id_link, 32'h14);
    chk("jal_taken", 32'(fbus.pc_src), 32'd1);
    step(32'h14, beq, 32'd5, 32'd5);
    chk("wrongpath_valid", 32'(id_valid), 32'd0);
    chk("wrongpath_pc_src", 32'(fbus.pc_src), 32'd0);
    step(32'h8, addi, 32'd5, 32'd5);
    chk("jal_cnt_once", redirect_cnt, cnt_before + 32'd1);

    // JALR x0,4(x5)
    step(32'h20, jalr, 32'd0, 32'd0);
    rs1_data = 32'h101; #1;
    chk("jalr_ext", fbus.imm_ext, 32'h0000_00E0);
    chk("jalr_taken", 32'(fbus.pc_src), 32'd1);
    step(32'h24, addi, 32'h101, 32'd0);

    // Random instruction stream
    for (int i = 0; i < 400; i++) begin
      w  = $urandom;
      if ($urandom_range(0, 9) == 0) w[6:0] = 7'($urandom);
      else w[6:0] = opcs[$urandom_range(0, 8)];
      r1 = pick_operand();
      r2 = ($urandom_range(0, 2) == 0) ? r1 : pick_operand();
      pc = $urandom & 32'hFFFF_FFFC;
      step(pc, w, r1, r2);
    end

    // Asynchronous reset in the middle of a taken JAL
    step(32'h10, jal, 32'd0, 32'd0);
    chk("pre_rst_taken", 32'(fbus.pc_src), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(id_valid), 32'd0);
    chk("mid_rst_cnt", redirect_cnt, 32'd0);
    chk("mid_rst_pc_src", 32'(fbus.pc_src), 32'd0);
    chk("mid_rst_instr", id_instr, NOP_W);
    chk("mid_rst_pc", id_pc, 32'h0);
    #1;
    reset = 1'b0;
    model_reset();
    step(32'h0, addi, 32'd0, 32'd0);
    step(32'h4, beq, 32'd0, 32'd0);
    step(32'h8, addi, 32'd3, 32'd3);
    step(32'hC, addi, 32'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_branch_stage.md
Name: id_branch_stage

Overview:
- Consumer end of the fetch interface.
- Latches the fetched instruction and PC into an IF/ID register, then decodes the immediate and register fields.
- Resolves conditional branches, JAL and JALR in decode, and drives the fetch unit's PCSrc / imm_ext redirect pair.
- Squashes the single wrong-path instruction fetched behind a taken redirect, and counts taken redirects for performance monitoring.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- RESET_PC, 32'h0, value of id_pc after reset.
- CNT_W, 32, width of the taken-redirect counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- if_pc  in  32  PC of the instruction currently presented by fetch.
- if_instr  in  32  instruction word at if_pc.
- rs1_data  in  32  register-file read data for rs1_addr (combinational read).
- rs2_data  in  32  register-file read data for rs2_addr.
- pc_src  out  1  redirect request to fetch (PCSrc).
- imm_ext  out  32  offset fetch adds to its current PC when pc_src=1.
- id_valid  out  1  IF/ID slot holds a live instruction.
- id_pc  out  32  PC of the instruction in the IF/ID slot.
- id_instr  out  32  instruction in the slot; forced to NOP 32'h00000013 when invalid.
- id_imm  out  32  sign-extended immediate (I/S/B/U/J formats).
- rs1_addr, rs2_addr, rd_addr  out  5 each  register fields of id_instr.
- id_link  out  32  id_pc+4, the link value for JAL/JALR.
- redirect_cnt  out  CNT_W  number of taken redirects since reset.

Behaviour:
- Reset (asynchronous): id_valid=0, id_pc=RESET_PC, id_instr=NOP, redirect_cnt=0, squash flag=0. All combinational outputs follow the NOP slot, so pc_src=0 and imm_ext=0.
- IF/ID register: captures if_pc/if_instr on every rising clk. There is no stall.
- id_valid next value = !squash_next.
- Squash flag:
  - Set for exactly one cycle when pc_src=1 at a clock edge.
  - The instruction captured at that same edge (the PC+4 wrong path) is written with id_valid=0 and id_instr=NOP.
- Immediate decode from opcode [6:0]:
  - I-type (0000011, 0010011, 1100111) and S-type (0100011) use their standard formats.
  - B-type (1100011): {imm[12:1],0} sign-extended.
  - J-type (1101111): {imm[20:1],0} sign-extended.
  - U-type (0110111, 0010111): {instr[31:12],12'b0}.
  - Any other opcode gives id_imm=0.
- Branch resolution, combinational, only when id_valid=1:
  - BEQ/BNE compare for equality.
  - BLT/BGE use a signed compare; BLTU/BGEU use an unsigned compare.
  - funct3 010/011 (illegal) gives not-taken.
  - JAL and JALR are always taken.
- Target:
  - B/JAL: id_pc+id_imm.
  - JALR: (rs1_data+id_imm) & ~1.
- Redirect contract:
  - Fetch has already advanced to id_pc+4 when the slot decodes.
  - imm_ext = target − (id_pc+4), computed modulo 2^32.
  - pc_src = taken. When not taken, imm_ext = 0.
- Timing: a taken branch in the slot during cycle N redirects fetch at the end of N. Fetch presents the target in N+1, and the slot is valid again from N+2. This gives a one-bubble penalty.
- Back-to-back redirects: a branch arriving in a squashed slot never asserts pc_src.
- redirect_cnt: increments on each edge with pc_src=1 and wraps modulo 2^CNT_W.
- Reset asserted mid-operation: slot and counter clear immediately. pc_src deasserts combinationally in the same cycle.
- rd_addr is reported raw. Gating of writes to x0 is handled downstream.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (OP_BRANCH, OP_JAL, OP_JALR, OP_LOAD, OP_STORE, OP_IMM, OP_LUI, OP_AUIPC);
  - funct3 branch codes;
  - NOP constant 32'h00000013;
  - immediate-format enum.
- One natural sub-module: imm_gen (purely combinational, instr -> id_imm). It is reused by later stages.

Test Plan:
- Reset then release with if_pc=0, if_instr=ADDI x1,x0,5 -> in the first cycle id_valid=0 and id_instr=NOP. After one edge: id_valid=1, id_imm=5, rd_addr=1, pc_src=0.
- BEQ x1,x2,+16 at id_pc=0x8 with rs1_data=rs2_data=7 -> pc_src=1, imm_ext=0x0000000C. On the next cycle id_valid=0 and redirect_cnt=1.
- Same BEQ with rs1_data=7, rs2_data=8 -> pc_src=0, imm_ext=0, and the next slot stays valid.
- BLT vs BLTU at id_pc=0x40 with rs1_data=0xFFFFFFFF, rs2_data=1 -> BLT is taken, BLTU is not taken.
- JAL x1,-8 at id_pc=0x10 -> imm_ext=0xFFFFFFF4, id_link=0x14. JALR x0,4(x5) at id_pc=0x20 with rs1_data=0x101 -> target 0x104, imm_ext=0x000000E0.
- Taken JAL immediately followed by a BEQ whose operands match (the wrong-path slot) -> the BEQ slot is squashed, pc_src stays 0, and redirect_cnt increments only once. Asserting reset mid-stream -> id_valid=0 and redirect_cnt=0 without waiting for a clock edge.
